rf_write_port_arbiter: RTL and testbench

//  Shares the RegisterFile's single write port (Rdst/RY/RF_WRITE) between the pipeline writeback stage (WB) and a

---
 rtl/rf_write_port_arbiter.sv | 115 +++++++++++
 tb/tb_rf_write_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_port_arbiter.sv
// Arbitrates the RegisterFile write port between WB and a multi-cycle unit, with an MC pending scoreboard.
// Optional build macro RF_R0_ZERO_EN makes R0 read-only-zero: its writes are acked but never committed.
module rf_write_port_arbiter #(
  parameter int NREG         = 32,
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rdst,
  input  logic [DW-1:0] wb_data,
  input  logic          mc_req,
  input  logic [AW-1:0] mc_rdst,
  input  logic [DW-1:0] mc_data,
  output logic          mc_ack,
  input  logic          iss_mc,
  input  logic [AW-1:0] iss_rdst,
  input  logic          use_rs1,
  input  logic [AW-1:0] rs1,
  input  logic          use_rs2,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] dec_rdst,
  input  logic          dec_wr,
  output logic          dec_stall,
  output logic          stall,
  output logic [AW-1:0] Rdst,
  output logic [DW-1:0] RY,
  output logic          RF_WRITE
);

  localparam logic [0:0] ST_NORM  = 1'b0;
  localparam logic [0:0] ST_FORCE = 1'b1;

  logic [0:0]      r_state;
  logic [CW-1:0]   r_starve_cnt;
  logic [NREG-1:0] r_pending;
  logic            r_src_mc;

  logic            w_force;
  logic            w_gnt_wb;
  logic            w_gnt_mc;
  logic            w_lose;
  logic [AW-1:0]   w_wr_addr;
  logic [DW-1:0]   w_wr_data;
  logic            w_wr_zero;
  logic            w_iss_zero;
  logic [NREG-1:0] w_pend_nxt;

  // FORCE hands the port to MC unconditionally; NORM gives WB priority.
  assign w_force   = (r_state == ST_FORCE);
  assign w_gnt_wb  = !w_force && wb_valid;
  assign w_gnt_mc  = mc_req && (w_force || !wb_valid);
  assign w_lose    = !w_force && mc_req && !w_gnt_mc;
  assign w_wr_addr = w_gnt_mc ? mc_rdst : wb_rdst;
  assign w_wr_data = w_gnt_mc ? mc_data : wb_data;

`ifdef RF_R0_ZERO_EN
  assign w_wr_zero  = (w_wr_addr == '0);
  assign w_iss_zero = (iss_rdst == '0);
`else
  assign w_wr_zero  = 1'b0;
  assign w_iss_zero = 1'b0;
`endif

  assign mc_ack    = w_gnt_mc && !reset;
  assign stall     = w_force;
  assign dec_stall = stall | (use_rs1 & r_pending[rs1]) | (use_rs2 & r_pending[rs2])
                   | (dec_wr & r_pending[dec_rdst]);

  // Clear is applied before set so a same-edge issue to the committing register stays pending.
  always_comb begin
    w_pend_nxt = r_pending;
    if (RF_WRITE && r_src_mc)
      w_pend_nxt[Rdst] = 1'b0;
    if (iss_mc && !w_iss_zero)
      w_pend_nxt[iss_rdst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_NORM;
      r_starve_cnt <= '0;
      r_pending    <= '0;
      r_src_mc     <= 1'b0;
      RF_WRITE     <= 1'b0;
      Rdst         <= '0;
      RY           <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      RF_WRITE  <= (w_gnt_wb || w_gnt_mc) && !w_wr_zero;
      if (w_gnt_wb || w_gnt_mc) begin
        Rdst     <= w_wr_addr;
        RY       <= w_wr_data;
        r_src_mc <= w_gnt_mc;
      end
      if (w_force) begin
        r_state      <= ST_NORM;
        r_starve_cnt <= '0;
      end else if (w_lose) begin
        if (r_starve_cnt == CW'(STARVE_LIMIT - 1)) begin
          r_state      <= ST_FORCE;
          r_starve_cnt <= '0;
        end else begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// Directed bench for rf_write_port_arbiter: reset, WB/MC writes, scoreboard stalls, starvation forcing.
module tb_rf_write_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_valid;
  logic [AW-1:0] wb_rdst;
  logic [DW-1:0] wb_data;
  logic          mc_req;
  logic [AW-1:0] mc_rdst;
  logic [DW-1:0] mc_data;
  logic          mc_ack;
  logic          iss_mc;
  logic [AW-1:0] iss_rdst;
  logic          use_rs1;
  logic [AW-1:0] rs1;
  logic          use_rs2;
  logic [AW-1:0] rs2;
  logic [AW-1:0] dec_rdst;
  logic          dec_wr;
  logic          dec_stall;
  logic          stall;
  logic [AW-1:0] Rdst;
  logic [DW-1:0] RY;
  logic          RF_WRITE;

  int checks = 0;
  int errors = 0;

  rf_write_port_arbiter #(.NREG(32), .AW(AW), .DW(DW), .STARVE_LIMIT(4), .CW(3)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rdst(wb_rdst), .wb_data(wb_data),
    .mc_req(mc_req), .mc_rdst(mc_rdst), .mc_data(mc_data), .mc_ack(mc_ack),
    .iss_mc(iss_mc), .iss_rdst(iss_rdst),
    .use_rs1(use_rs1), .rs1(rs1), .use_rs2(use_rs2), .rs2(rs2),
    .dec_rdst(dec_rdst), .dec_wr(dec_wr), .dec_stall(dec_stall),
    .stall(stall), .Rdst(Rdst), .RY(RY), .RF_WRITE(RF_WRITE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_rdst = 0; wb_data = 0;
    mc_req = 0; mc_rdst = 0; mc_data = 0;
    iss_mc = 0; iss_rdst = 0;
    use_rs1 = 0; rs1 = 0; use_rs2 = 0; rs2 = 0;
    dec_rdst = 0; dec_wr = 0;
  endtask

  initial begin
    // 1: reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wb_valid = 1'($urandom); wb_rdst = AW'($urandom); wb_data = $urandom;
      mc_req = 1'b1; mc_rdst = AW'($urandom); mc_data = $urandom;
      iss_mc = 1'($urandom); iss_rdst = AW'($urandom);
      use_rs1 = 1'($urandom); rs1 = AW'($urandom); use_rs2 = 1'($urandom); rs2 = AW'($urandom);
      dec_rdst = AW'($urandom); dec_wr = 1'($urandom);
      tick();
    end
    check("rst_rf_write", 32'(RF_WRITE), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_dec_stall", 32'(dec_stall), 0);
    check("rst_mc_ack", 32'(mc_ack), 0);
    check("rst_rdst", 32'(Rdst), 0);
    check("rst_ry", RY, 0);
    reset = 1'b0;
    idle();
    tick();

    // 2: single WB write
    wb_valid = 1; wb_rdst = 5; wb_data = 32'hDEADBEEF;
    #1 check("wb_no_ack", 32'(mc_ack), 0);
    tick();
    idle();
    check("wb_rf_write", 32'(RF_WRITE), 1);
    check("wb_rdst", 32'(Rdst), 5);
    check("wb_ry", RY, 32'hDEADBEEF);
    tick();
    check("wb_rf_write_off", 32'(RF_WRITE), 0);
    check("wb_rdst_hold", 32'(Rdst), 5);
    check("wb_ry_hold", RY, 32'hDEADBEEF);

    // 3: RAW on pending MC result for R7
    iss_mc = 1; iss_rdst = 7;
    tick();
    iss_mc = 0; use_rs1 = 1; rs1 = 7;
    #1 check("raw_stall0", 32'(dec_stall), 1);
    tick();
    check("raw_stall1", 32'(dec_stall), 1);
    rs1 = 8;
    #1 check("raw_other_reg", 32'(dec_stall), 0);
    use_rs1 = 0; use_rs2 = 1; rs2 = 7;
    #1 check("raw_rs2", 32'(dec_stall), 1);
    use_rs2 = 0; dec_wr = 1; dec_rdst = 7;
    #1 check("waw_stall", 32'(dec_stall), 1);
    dec_wr = 0; use_rs1 = 1; rs1 = 7;
    mc_req = 1; mc_rdst = 7; mc_data = 32'h1234;
    #1 check("raw_mc_ack", 32'(mc_ack), 1);
    tick();
    mc_req = 0;
    check("raw_rf_write", 32'(RF_WRITE), 1);
    check("raw_rdst", 32'(Rdst), 7);
    check("raw_ry", RY, 32'h1234);
    check("raw_stall_commit", 32'(dec_stall), 1);
    tick();
    check("raw_released", 32'(dec_stall), 0);

    // same-edge set and clear on R7: set wins
    iss_mc = 1; iss_rdst = 7;
    tick();
    iss_mc = 0;
    mc_req = 1; mc_rdst = 7; mc_data = 32'h5678;
    tick();
    mc_req = 0;
    iss_mc = 1; iss_rdst = 7;
    check("sw_rdst", 32'(Rdst), 7);
    tick();
    iss_mc = 0;
    check("set_wins", 32'(dec_stall), 1);
    mc_req = 1; mc_rdst = 7; mc_data = 32'h9ABC;
    tick();
    mc_req = 0;
    tick();
    check("set_wins_cleared", 32'(dec_stall), 0);
    idle();
    tick();

    // 4: starvation -> FORCE after 4 WB grants
    wb_valid = 1; wb_rdst = 1; wb_data = 32'h100;
    mc_req = 1; mc_rdst = 2; mc_data = 32'h200;
    for (int i = 0; i < 4; i++) begin
      #1 check("starve_stall", 32'(stall), 0);
      check("starve_no_ack", 32'(mc_ack), 0);
      tick();
      check("starve_wb_rdst", 32'(Rdst), 1);
      check("starve_wb_wr", 32'(RF_WRITE), 1);
    end
    check("force_stall", 32'(stall), 1);
    check("force_ack", 32'(mc_ack), 1);
    tick();
    mc_req = 0;
    check("force_mc_rdst", 32'(Rdst), 2);
    check("force_mc_ry", RY, 32'h200);
    check("force_end", 32'(stall), 0);
    tick();
    wb_valid = 0;
    check("held_wb_rdst", 32'(Rdst), 1);
    check("held_wb_ry", RY, 32'h100);
    idle();
    tick();

    // 5: simultaneous WB and MC in NORM
    wb_valid = 1; wb_rdst = 3; wb_data = 32'h33;
    mc_req = 1; mc_rdst = 9; mc_data = 32'h99;
    #1 check("sim_no_ack", 32'(mc_ack), 0);
    tick();
    wb_valid = 0;
    check("sim_first_rdst", 32'(Rdst), 3);
    #1 check("sim_ack", 32'(mc_ack), 1);
    tick();
    mc_req = 0;
    check("sim_second_rdst", 32'(Rdst), 9);
    check("sim_second_wr", 32'(RF_WRITE), 1);
    idle();
    tick();

    // 6: reset mid-operation
    iss_mc = 1; iss_rdst = 7;
    tick();
    iss_mc = 0;
    mc_req = 1; mc_rdst = 7; mc_data = 32'h77;
    reset = 1;
    #1 check("midrst_ack", 32'(mc_ack), 0);
    tick();
    check("midrst_wr", 32'(RF_WRITE), 0);
    check("midrst_stall", 32'(stall), 0);
    reset = 0; mc_req = 0; use_rs1 = 1; rs1 = 7;
    #1 check("midrst_pending", 32'(dec_stall), 0);
    idle();
    wb_valid = 1; wb_rdst = 0; wb_data = 32'hABCD;
    tick();
    wb_valid = 0;
`ifdef RF_R0_ZERO_EN
    check("r0_no_write", 32'(RF_WRITE), 0);
`else
    check("r0_write", 32'(RF_WRITE), 1);
    check("r0_rdst", 32'(Rdst), 0);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
